// File: rtl/mel_pkg.sv
// Shared definitions for the mel band scheduler: sizes, index typedefs,
// FSM state encoding, per-beat metadata and the mel filterbank edge table.
package mel_pkg;

   localparam int N_BANDS = 88;
   localparam int N_BINS  = 513;
   localparam int BIN_W   = 10;
   localparam int BAND_W  = 7;

   typedef logic [BIN_W-1:0]  bin_t;
   typedef logic [BAND_W-1:0] band_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STREAM,
      ST_DRAIN
   } state_t;

   // Metadata that travels with each read; fin marks the last beat of the frame.
   typedef struct packed {
      bin_t  idx;
      band_t num;
      logic  first;
      logic  last;
      logic  fin;
   } meta_t;

   localparam bin_t  MAX_BIN   = bin_t'(N_BINS - 1);
   localparam band_t LAST_BAND = band_t'(N_BANDS - 1);

   // Band edges on the mel scale for 513 bins; band k spans edge[k]..edge[k+2].
   localparam int MEL_EDGES [N_BANDS+2] = '{
        0,   2,   4,   4,   5,   7,   8,  10,  11,  13,
       15,  16,  18,  20,  22,  24,  26,  28,  30,  32,
       34,  36,  39,  41,  44,  46,  49,  51,  54,  57,
       60,  63,  66,  69,  73,  76,  79,  83,  87,  90,
       94,  98, 102, 107, 111, 115, 120, 125, 130, 135,
      140, 145, 151, 156, 162, 168, 174, 180, 187, 193,
      200, 207, 214, 222, 230, 237, 246, 254, 262, 271,
      280, 290, 299, 309, 319, 330, 341, 352, 363, 375,
      387, 399, 412, 425, 439, 453, 467, 482, 497, 512
   };

endpackage

// File: rtl/mel_edge_rom.sv
// Combinational lookup of the lower and upper edge of one mel band.
module mel_edge_rom
   import mel_pkg::*;
(
   input  logic [6:0] band,
   output logic [9:0] lo_edge,
   output logic [9:0] hi_edge
);

   // Band k starts at edge[k] and ends at edge[k+2].
   always_comb begin
      lo_edge = bin_t'(MEL_EDGES[int'(band)]);
      hi_edge = bin_t'(MEL_EDGES[int'(band) + 2]);
   end

endmodule

// File: rtl/mel_band_sched.sv
// Frame scheduler: walks the mel bands, reads each band's bins from the bin
// buffer and streams them with index/band/first/last tags.
// Optional downstream back-pressure with a 2-entry skid buffer: MEL_SCHED_STALL_EN.
module mel_band_sched
   import mel_pkg::*;
#(
   parameter int I_BW = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   rd_en,
   output logic [9:0]             rd_addr,
   input  logic signed [I_BW-1:0] rd_data,
   output logic                   do_en,
   output logic signed [I_BW-1:0] data_o,
   output logic [9:0]             group_idx,
   output logic [6:0]             group_num,
   output logic                   is_first,
`ifdef MEL_SCHED_STALL_EN
   input  logic                   ds_ready,
`endif
   output logic                   is_last
);

   state_t state, state_nxt;
   band_t  band;
   bin_t   bin, lo, hi;
   bin_t   edge_lo, edge_hi, hi_clip;
   logic   at_hi, can_issue, xfer;
   meta_t  meta_cur, meta_p0, meta_p1;
   logic   vld_p0, vld_p1;
   logic signed [I_BW-1:0] data_p1;

   mel_edge_rom u_rom (
      .band    (band),
      .lo_edge (edge_lo),
      .hi_edge (edge_hi)
   );

   // A reversed table entry collapses the band to a single bin at lo.
   assign hi_clip  = (edge_hi < edge_lo) ? edge_lo :
                     (edge_hi > MAX_BIN) ? MAX_BIN : edge_hi;
   assign at_hi    = (bin == hi);
   assign meta_cur = '{idx: bin, num: band, first: (bin == lo), last: at_hi,
                       fin: (at_hi && band == LAST_BAND)};

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // FSM next-state: start only matters in IDLE; DRAIN ends when the final beat leaves.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_STREAM;
         ST_STREAM: if (rd_en && at_hi) state_nxt = (band == LAST_BAND) ? ST_DRAIN : ST_LOAD;
         ST_DRAIN:  if (frame_done && xfer) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: read strobe/address while streaming, busy whenever not idle.
   always_comb begin
      busy    = (state != ST_IDLE);
      rd_en   = (state == ST_STREAM) && can_issue;
      rd_addr = rd_en ? bin : '0;
   end

   // Band and bin counters; LOAD latches the band window from the edge table.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         band <= '0;
         bin  <= '0;
         lo   <= '0;
         hi   <= '0;
      end else begin
         case (state)
            ST_IDLE:   if (start) band <= '0;
            ST_LOAD: begin
               lo  <= edge_lo;
               hi  <= hi_clip;
               bin <= edge_lo;
            end
            ST_STREAM: if (rd_en) begin
               bin <= bin + 10'd1;
               if (at_hi && band != LAST_BAND) band <= band + 7'd1;
            end
            default: ;
         endcase
      end
   end

   // Stage p0: metadata waits one cycle alongside the RAM read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p0  <= 1'b0;
         meta_p0 <= '0;
      end else begin
         vld_p0  <= rd_en;
         meta_p0 <= rd_en ? meta_cur : '0;
      end
   end

`ifdef MEL_SCHED_STALL_EN
   logic [1:0]             sk_cnt;
   logic signed [I_BW-1:0] sk_data [2];
   meta_t                  sk_meta [2];
   logic [2:0]             occ;

   // Reads are issued only if every beat already committed still has a slot
   // (output register plus two skid entries) when it returns.
   assign xfer      = vld_p1 & ds_ready;
   assign occ       = 3'(vld_p0) + 3'(sk_cnt) + 3'(vld_p1) - 3'(xfer);
   assign can_issue = (occ <= 3'd2);

   // Stage p1: output register refills from the skid buffer first, else straight from the RAM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         meta_p1 <= '0;
         sk_cnt  <= '0;
         for (int i = 0; i < 2; i++) begin
            sk_data[i] <= '0;
            sk_meta[i] <= '0;
         end
      end else if (!vld_p1 || xfer) begin
         if (sk_cnt != 2'd0) begin
            vld_p1     <= 1'b1;
            data_p1    <= sk_data[0];
            meta_p1    <= sk_meta[0];
            sk_data[0] <= sk_data[1];
            sk_meta[0] <= sk_meta[1];
            if (vld_p0) begin
               if (sk_cnt == 2'd1) begin
                  sk_data[0] <= rd_data;
                  sk_meta[0] <= meta_p0;
               end else begin
                  sk_data[1] <= rd_data;
                  sk_meta[1] <= meta_p0;
               end
            end else begin
               sk_cnt <= sk_cnt - 2'd1;
            end
         end else if (vld_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= rd_data;
            meta_p1 <= meta_p0;
         end else begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            meta_p1 <= '0;
         end
      end else if (vld_p0) begin
         if (sk_cnt == 2'd0) begin
            sk_data[0] <= rd_data;
            sk_meta[0] <= meta_p0;
         end else begin
            sk_data[1] <= rd_data;
            sk_meta[1] <= meta_p0;
         end
         sk_cnt <= sk_cnt + 2'd1;
      end
   end
`else
   assign xfer      = vld_p1;
   assign can_issue = 1'b1;

   // Stage p1: register RAM data together with its metadata.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         meta_p1 <= '0;
      end else begin
         vld_p1  <= vld_p0;
         data_p1 <= vld_p0 ? rd_data : '0;
         meta_p1 <= meta_p0;
      end
   end
`endif

   assign do_en      = vld_p1;
   assign data_o     = data_p1;
   assign group_idx  = meta_p1.idx;
   assign group_num  = meta_p1.num;
   assign is_first   = meta_p1.first;
   assign is_last    = meta_p1.last;
   assign frame_done = vld_p1 & meta_p1.fin;

endmodule

// File: tb/tb_mel_band_sched.sv
// Self-checking bench for mel_band_sched: a bin-buffer model feeds the DUT and
// a band-walk model built from the edge table predicts every output beat.
module tb_mel_band_sched;
   import mel_pkg::*;

   localparam int I_BW = 14;

   typedef struct {
      int idx;
      int num;
      int first;
      int last;
      int d;
   } beat_t;

   logic clk = 1'b0;
   logic rst, start, ds_ready;
   logic busy, frame_done, rd_en, do_en, is_first, is_last;
   logic [9:0] rd_addr, group_idx;
   logic [6:0] group_num;
   logic signed [I_BW-1:0] rd_data = '0;
   logic signed [I_BW-1:0] data_o;

   logic signed [I_BW-1:0] mem [N_BINS];
   beat_t exp_q [$];
   int nvec = 0, nerr = 0;
   int cyc = 0, e0 = 0, beats = 0, fd_cnt = 0, fd_base = 0;
   int last_num = 0, last_beat_cyc = 0;

   mel_band_sched #(.I_BW(I_BW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .do_en      (do_en),
      .data_o     (data_o),
      .group_idx  (group_idx),
      .group_num  (group_num),
      .is_first   (is_first),
`ifdef MEL_SCHED_STALL_EN
      .ds_ready   (ds_ready),
`endif
      .is_last    (is_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bin buffer: one-cycle read latency.
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   task automatic chk(string name, int act, int exp);
      nvec++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_mem(int seed);
      for (int a = 0; a < N_BINS; a++) mem[a] = I_BW'(a * seed + 100);
   endtask

   // Expected beat stream for a whole frame, straight from the band definition.
   task automatic build_model();
      exp_q.delete();
      for (int k = 0; k < N_BANDS; k++) begin
         int lo, hi;
         lo = MEL_EDGES[k];
         hi = MEL_EDGES[k+2];
         if (hi > N_BINS - 1) hi = N_BINS - 1;
         if (hi < lo) hi = lo;
         for (int b = lo; b <= hi; b++) begin
            beat_t e;
            e.idx = b; e.num = k;
            e.first = int'(b == lo); e.last = int'(b == hi);
            e.d = int'(mem[b]);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic chk_idle(string tag);
      chk({tag, "_busy"},       int'(busy), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_rd_en"},      int'(rd_en), 0);
      chk({tag, "_rd_addr"},    int'(rd_addr), 0);
      chk({tag, "_do_en"},      int'(do_en), 0);
      chk({tag, "_data_o"},     int'(data_o), 0);
      chk({tag, "_group_idx"},  int'(group_idx), 0);
      chk({tag, "_group_num"},  int'(group_num), 0);
      chk({tag, "_is_first"},   int'(is_first), 0);
      chk({tag, "_is_last"},    int'(is_last), 0);
   endtask

   task automatic start_frame(int seed);
      fill_mem(seed);
      build_model();
      beats = 0; last_num = 0; fd_base = fd_cnt;
      start = 1'b1;
      @(negedge clk);
      e0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(int budget);
      int n = 0;
      while (fd_cnt == fd_base && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("frame_done_seen", int'(fd_cnt != fd_base), 1);
   endtask

   // Compare process: every accepted beat is checked against the model.
   initial begin
      beat_t e;
      int hold_prev;
      int hp_data, hp_idx, hp_num, hp_fl;
      hold_prev = 0; hp_data = 0; hp_idx = 0; hp_num = 0; hp_fl = 0;
      ds_ready = 1'b1;
      forever begin
         @(negedge clk);
`ifdef MEL_SCHED_STALL_EN
         if (hold_prev != 0 && rst) begin
            chk("hold_data", int'(data_o), hp_data);
            chk("hold_idx", int'(group_idx), hp_idx);
            chk("hold_num", int'(group_num), hp_num);
            chk("hold_flags", int'({is_first, is_last, frame_done, do_en}), hp_fl);
         end
         ds_ready = 1'($urandom_range(0, 1));
`endif
         if (do_en && ds_ready) begin
            if (exp_q.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL extra_beat: got beat idx %0d band %0d, expected none", group_idx, group_num);
            end else begin
               e = exp_q.pop_front();
               chk("idx", int'(group_idx), e.idx);
               chk("num", int'(group_num), e.num);
               chk("first", int'(is_first), e.first);
               chk("last", int'(is_last), e.last);
               chk("data", int'(data_o), e.d);
               chk("frame_done", int'(frame_done), int'(exp_q.size() == 0));
            end
            if (beats == 0) begin
               chk("first_beat_idx", int'(group_idx), 0);
               chk("first_beat_num", int'(group_num), 0);
               chk("first_beat_flag", int'(is_first), 1);
`ifndef MEL_SCHED_STALL_EN
               chk("first_beat_latency", cyc - e0, 3);
`endif
            end
            if (beats == 4) begin
               chk("band0_last_idx", int'(group_idx), 4);
               chk("band0_last_flag", int'(is_last), 1);
            end
            if (beats == 5) begin
               chk("band1_first_idx", int'(group_idx), 2);
               chk("band1_num", int'(group_num), 1);
               chk("band1_first_flag", int'(is_first), 1);
`ifndef MEL_SCHED_STALL_EN
               chk("band1_gap", cyc - last_beat_cyc, 2);
`endif
            end
            if (frame_done) begin
               chk("final_num", int'(group_num), 87);
               chk("final_idx", int'(group_idx), 512);
               chk("final_last", int'(is_last), 1);
               chk("frame_beats", beats + 1, 1095);
`ifndef MEL_SCHED_STALL_EN
               chk("frame_latency", cyc - e0, 1184);
`endif
               fd_cnt++;
            end
            beats++;
            last_num = int'(group_num);
            last_beat_cyc = cyc;
         end
`ifdef MEL_SCHED_STALL_EN
         hold_prev = int'(do_en && !ds_ready && rst);
         hp_data = int'(data_o); hp_idx = int'(group_idx); hp_num = int'(group_num);
         hp_fl = int'({is_first, is_last, frame_done, do_en});
`endif
      end
   end

   initial begin
      int n;
      rst = 1'b0;
      start = 1'b0;
      fill_mem(37);
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Full frame with an extra start while busy.
      start_frame(37);
      repeat (300) @(negedge clk);
      chk("busy_mid_frame", int'(busy), 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(6000);
      @(negedge clk);
      chk("busy_after_frame", int'(busy), 0);
      repeat (50) @(negedge clk);
      chk("frame_done_count", fd_cnt - fd_base, 1);
      chk("model_drained", exp_q.size(), 0);

      // Reset in the middle of band 10.
      start_frame(-53);
      n = 0;
      while (last_num != 10 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("reached_band10", last_num, 10);
      rst = 1'b0;
      @(negedge clk);
      chk_idle("mid_reset");
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("no_done_after_reset", fd_cnt - fd_base, 0);

      // Fresh frame after reset restarts at band 0, bin 0.
      start_frame(11);
      wait_done(6000);
      @(negedge clk);
      chk("busy_after_restart", int'(busy), 0);
      repeat (10) @(negedge clk);
      chk("restart_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
